// File: rtl/unsigned_clz_divider_pkg.sv
// Shared types and constants for the CLZ-bounded unsigned restoring divider.
// Optional build macro: DIV_RADIX4_EN (two subtract steps per RUN cycle).
package unsigned_clz_divider_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_W      = $clog2(DIV_DATA_WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/unsigned_clz_divider_if.sv
// Requester <-> divider bundle: operands with leading-zero counts in,
// quotient/remainder with a one-cycle done pulse out.
interface unsigned_clz_divider_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(DATA_WIDTH);

  logic                  start;
  logic [DATA_WIDTH-1:0] dividend;
  logic [CW-1:0]         dividend_CLZ;
  logic [DATA_WIDTH-1:0] divisor;
  logic [CW-1:0]         divisor_CLZ;
  logic                  divisor_is_zero;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  done;

  modport master (
    output start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
    input  quotient, remainder, done
  );

  modport slave (
    input  start, dividend, dividend_CLZ, divisor, divisor_CLZ, divisor_is_zero,
    output quotient, remainder, done
  );
endinterface

// File: rtl/unsigned_clz_divider_div_step.sv
// One restoring-division step: subtract the aligned divisor when it fits.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] sdiv_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  q_o
);
  logic [DATA_WIDTH:0] diff;

  // One extra bit holds the borrow out of the subtraction.
  always_comb begin
    diff  = {1'b0, rem_i} - {1'b0, sdiv_i};
    q_o   = ~diff[DATA_WIDTH];
    rem_o = diff[DATA_WIDTH] ? rem_i : diff[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/unsigned_clz_divider.sv
// Iterative unsigned restoring divider. Leading-zero counts align the divisor
// under the dividend's MSB so only shift+1 quotient bits are iterated.
// Optional build macro: DIV_RADIX4_EN retires two quotient bits per cycle.
module unsigned_clz_divider
  import unsigned_clz_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  unsigned_clz_divider_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] sdiv_q, sdiv_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         shift;
  logic [DATA_WIDTH-1:0] rem1;
  logic                  bit1;

  // Only used on the non-trivial path, where divisor_CLZ >= dividend_CLZ.
  assign shift = bus.divisor_CLZ - bus.dividend_CLZ;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step1 (
    .rem_i (rem_q),
    .sdiv_i(sdiv_q),
    .rem_o (rem1),
    .q_o   (bit1)
  );

`ifdef DIV_RADIX4_EN
  logic                  odd_q, odd_d;
  logic [DATA_WIDTH-1:0] sdiv_half;
  logic [DATA_WIDTH-1:0] rem2;
  logic                  bit2;
  logic                  single_step;

  assign sdiv_half   = sdiv_q >> 1;
  // Last cycle of an even shift retires just one bit.
  assign single_step = (cnt_q == '0) && !odd_q;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step2 (
    .rem_i (rem1),
    .sdiv_i(sdiv_half),
    .rem_o (rem2),
    .q_o   (bit2)
  );
`endif

  // Next-state logic: start always wins and restarts; otherwise iterate in RUN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sdiv_d  = sdiv_q;
    quot_d  = quot_q;
    done_d  = 1'b0;
`ifdef DIV_RADIX4_EN
    odd_d   = odd_q;
`endif
    if (bus.start) begin
      rem_d = bus.dividend;
      if (bus.divisor_is_zero) begin
        quot_d  = '1;
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (bus.divisor_CLZ < bus.dividend_CLZ) begin
        quot_d  = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        sdiv_d  = bus.divisor << shift;
        quot_d  = '0;
        state_d = RUN;
`ifdef DIV_RADIX4_EN
        cnt_d   = shift >> 1;
        odd_d   = shift[0];
`else
        cnt_d   = shift;
`endif
      end
    end else if (state_q == RUN) begin
`ifdef DIV_RADIX4_EN
      if (single_step) begin
        rem_d  = rem1;
        quot_d = {quot_q[DATA_WIDTH-2:0], bit1};
        sdiv_d = sdiv_q >> 1;
      end else begin
        rem_d  = rem2;
        quot_d = {quot_q[DATA_WIDTH-3:0], bit1, bit2};
        sdiv_d = sdiv_q >> 2;
      end
`else
      rem_d  = rem1;
      quot_d = {quot_q[DATA_WIDTH-2:0], bit1};
      sdiv_d = sdiv_q >> 1;
`endif
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sdiv_q  <= '0;
      quot_q  <= '0;
      done_q  <= 1'b0;
`ifdef DIV_RADIX4_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sdiv_q  <= sdiv_d;
      quot_q  <= quot_d;
      done_q  <= done_d;
`ifdef DIV_RADIX4_EN
      odd_q   <= odd_d;
`endif
    end
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.done      = done_q;
endmodule
